// File: rtl/br_arb_grant_skid_pkg.sv
// Shared constants for the arbiter grant skid buffer.
// Defaults match the reference two-requester configuration.
package br_arb_grant_skid_pkg;
   localparam int DefNumRequesters = 2;
   localparam int DefWidth         = 8;
   localparam int CountWidth       = 32;
endpackage

// File: rtl/br_arb_grant_skid_if.sv
// Push/arbiter/pop bundle for br_arb_grant_skid.
// pop_count exists only with BR_ARB_GRANT_SKID_STATS_EN.
interface br_arb_grant_skid_if
   import br_arb_grant_skid_pkg::*;
#(
   parameter int NumRequesters = DefNumRequesters,
   parameter int Width         = DefWidth
);
   localparam int SourceWidth = $clog2(NumRequesters);

   logic [NumRequesters-1:0]            push_valid;
   logic [NumRequesters-1:0]            push_ready;
   logic [NumRequesters-1:0][Width-1:0] push_data;
   logic [NumRequesters-1:0]            arb_request;
   logic                                arb_enable_priority_update;
   logic [NumRequesters-1:0]            arb_grant;
   logic                                pop_valid;
   logic                                pop_ready;
   logic [Width-1:0]                    pop_data;
   logic [SourceWidth-1:0]              pop_source;
`ifdef BR_ARB_GRANT_SKID_STATS_EN
   logic [CountWidth-1:0]               pop_count;
`endif

   modport slave (
      input  push_valid, push_data, arb_grant, pop_ready,
      output push_ready, arb_request, arb_enable_priority_update,
      output pop_valid, pop_data, pop_source
`ifdef BR_ARB_GRANT_SKID_STATS_EN
      , output pop_count
`endif
   );

   modport master (
      output push_valid, push_data, arb_grant, pop_ready,
      input  push_ready, arb_request, arb_enable_priority_update,
      input  pop_valid, pop_data, pop_source
`ifdef BR_ARB_GRANT_SKID_STATS_EN
      , input pop_count
`endif
   );
endinterface

// File: rtl/br_arb_grant_skid_slot.sv
// One buffered beat (valid, data, source) with load and clear.
// Load wins over clear so a pop+refill in one cycle keeps the slot full.
module br_arb_grant_skid_slot #(
   parameter int Width       = 8,
   parameter int SourceWidth = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_load,
   input  logic                   i_clear,
   input  logic [Width-1:0]       i_data,
   input  logic [SourceWidth-1:0] i_source,
   output logic                   o_valid,
   output logic [Width-1:0]       o_data,
   output logic [SourceWidth-1:0] o_source
);
   logic                   r_valid;
   logic [Width-1:0]       r_data;
   logic [SourceWidth-1:0] r_source;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_source <= '0;
      end else if (i_load) begin
         r_valid  <= 1'b1;
         r_data   <= i_data;
         r_source <= i_source;
      end else if (i_clear) begin
         r_valid  <= 1'b0;
      end
   end

   assign o_valid  = r_valid;
   assign o_data   = r_data;
   assign o_source = r_source;
endmodule

// File: rtl/br_arb_grant_skid.sv
// Captures the arbiter winner into a main+skid buffer feeding one pop port.
// Define BR_ARB_GRANT_SKID_STATS_EN for a saturating 32-bit pop counter.
module br_arb_grant_skid
   import br_arb_grant_skid_pkg::*;
#(
   parameter int NumRequesters = DefNumRequesters,
   parameter int Width         = DefWidth
) (
   input logic                clk,
   input logic                rst_n,
   br_arb_grant_skid_if.slave bus
);
   localparam int SourceWidth = $clog2(NumRequesters);

   logic                   w_can_accept;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_main_load;
   logic                   w_skid_load;
   logic                   w_skid_clear;
   logic                   w_main_valid;
   logic                   w_skid_valid;
   logic [Width-1:0]       w_cap_data;
   logic [Width-1:0]       w_main_data;
   logic [Width-1:0]       w_skid_data;
   logic [Width-1:0]       w_main_in_data;
   logic [SourceWidth-1:0] w_cap_src;
   logic [SourceWidth-1:0] w_main_src;
   logic [SourceWidth-1:0] w_skid_src;
   logic [SourceWidth-1:0] w_main_in_src;

   // Gating on skid occupancy only keeps pop_ready off the push paths.
   assign w_can_accept = !w_skid_valid;
   assign bus.arb_request = bus.push_valid & {NumRequesters{w_can_accept}};
   assign bus.arb_enable_priority_update = w_can_accept;
   assign bus.push_ready = bus.arb_grant & {NumRequesters{w_can_accept}};

   assign w_push = |(bus.push_ready & bus.push_valid);
   assign w_pop  = w_main_valid & bus.pop_ready;

   always_comb begin
      w_cap_data = '0;
      w_cap_src  = '0;
      for (int i = 0; i < NumRequesters; i++) begin
         if (bus.arb_grant[i]) begin
            w_cap_data = w_cap_data | bus.push_data[i];
            w_cap_src  = w_cap_src | SourceWidth'(i);
         end
      end
   end

   assign w_main_load = (w_pop & w_skid_valid)
                      | (w_push & (!w_main_valid | w_pop));
   assign w_skid_load  = w_push & w_main_valid & !w_pop;
   assign w_skid_clear = w_pop & w_skid_valid;

   assign w_main_in_data = w_skid_valid ? w_skid_data : w_cap_data;
   assign w_main_in_src  = w_skid_valid ? w_skid_src  : w_cap_src;

   br_arb_grant_skid_slot #(
      .Width       (Width),
      .SourceWidth (SourceWidth)
   ) u_main (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_main_load),
      .i_clear  (w_pop),
      .i_data   (w_main_in_data),
      .i_source (w_main_in_src),
      .o_valid  (w_main_valid),
      .o_data   (w_main_data),
      .o_source (w_main_src)
   );

   br_arb_grant_skid_slot #(
      .Width       (Width),
      .SourceWidth (SourceWidth)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_skid_load),
      .i_clear  (w_skid_clear),
      .i_data   (w_cap_data),
      .i_source (w_cap_src),
      .o_valid  (w_skid_valid),
      .o_data   (w_skid_data),
      .o_source (w_skid_src)
   );

   assign bus.pop_valid  = w_main_valid;
   assign bus.pop_data   = w_main_data;
   assign bus.pop_source = w_main_src;

`ifdef BR_ARB_GRANT_SKID_STATS_EN
   logic [CountWidth-1:0] r_pop_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pop_count <= '0;
      end else if (w_pop && (r_pop_count != '1)) begin
         r_pop_count <= r_pop_count + CountWidth'(1);
      end
   end

   assign bus.pop_count = r_pop_count;
`endif

   a_grant_onehot0: assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(bus.arb_grant));
   a_grant_subset: assert property (
      @(posedge clk) disable iff (!rst_n)
      (bus.arb_grant & ~bus.arb_request) == '0);
endmodule

// File: doc/br_arb_grant_skid.md
# br_arb_grant_skid

Downstream companion of the LRU arbiter (`br_arb_lru`). It takes N valid/ready push ports, presents their valids to the arbiter as `request`, and consumes the one-hot `grant` to capture the winner's payload. The captured payload goes into a 2-entry skid register that drives a single valid/ready pop port. Arbitration and LRU priority updates happen only when the block can accept a beat, so backpressure never skews fairness.

## Interface
- `NumRequesters`, 2: number of push ports; must be ≥2.
- `Width`, 8: payload width; must be ≥1.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `push_valid`  in  NumRequesters  per-requester valid.
- `push_ready`  out  NumRequesters  per-requester ready.
- `push_data`  in  NumRequesters×Width  per-requester payload.
- `arb_request`  out  NumRequesters  drives arbiter `request`.
- `arb_enable_priority_update`  out  1  drives arbiter `enable_priority_update`.
- `arb_grant`  in  NumRequesters  arbiter `grant`; onehot0, subset of `arb_request`.
- `pop_valid`  out  1  output valid.
- `pop_ready`  in  1  output ready.
- `pop_data`  out  Width  output payload.
- `pop_source`  out  $clog2(NumRequesters)  index of the requester that supplied `pop_data`.

## Operation
- State: `main` slot (valid, data, source) and `skid` slot (valid, data, source).
- `can_accept = !skid_valid`.
- `arb_request = push_valid & {N{can_accept}}`.
- `arb_enable_priority_update = can_accept`.
- `push_ready[i] = arb_grant[i] & can_accept`. At most one push handshakes per cycle.
- Captured beat: `push_data`/index of the granted requester, selected by a one-hot mux. Zero-extend the index to `pop_source` width.
- Pop side: `pop_valid = main_valid`, `pop_data = main_data`, `pop_source = main_source`.
- Push with main empty, or main popping this cycle: beat goes to main.
- Push with main full and not popping: beat goes to skid.
- Pop while skid is valid: skid moves into main, skid clears.
- Simultaneous push and pop with skid empty: main is replaced by the new beat and skid stays empty. This gives full throughput.
- Push is impossible while skid is valid, because `can_accept` is 0.
- Ordering: beats leave in acceptance order.
- Payload on `pop_data` is stable while `pop_valid` is high and `pop_ready` is low.
- Assertions (always on):
  - `arb_grant` is onehot0.
  - `arb_grant` is a subset of `arb_request`.
  - Push valid/data stability under backpressure is the upstream's obligation and is not checked here.

## Timing
- Latency push→pop: 1 cycle. A beat accepted at edge k is visible on `pop_*` after edge k.
- Combinational paths:
  - `push_valid` → `arb_request`.
  - `arb_grant` → `push_ready`.
- No combinational path from `pop_ready` to any push or arbiter output; this is the purpose of the skid slot.
- Reset values (asynchronous on `rst_n` low):
  - `main_valid`, `skid_valid` = 0.
  - data/source registers = 0.
  - Resulting outputs: `pop_valid` 0, `pop_data` 0, `pop_source` 0.
  - `arb_enable_priority_update` 1.
- Reset asserted mid-operation drops both slots immediately. In-flight beats are lost.
- Sustained throughput: 1 beat/cycle with `pop_ready` held high.

## Configuration
- `BR_ARB_GRANT_SKID_STATS_EN` defined: adds output `pop_count` (32 bits).
  - Increments on each pop handshake; saturates at 2^32−1.
  - Resets to 0.
- Not defined: no `pop_count` port and no counter logic.

## Structure
- No package types are needed.
- Width rule lives in a local param: `SourceWidth = $clog2(NumRequesters)`.
- Natural sub-module: `br_arb_grant_skid_slot`, one slot register with a load enable, instantiated twice.

## Test plan
- Single beat: N=2, push 0 valid with data 0xA5, `pop_ready`=1.
  - `arb_request`=0b01, `push_ready`=0b01.
  - Next cycle: `pop_data`=0xA5, `pop_source`=0.
- Contention: both pushes valid with data 0x11/0x22 for 4 cycles, LRU arbiter attached, `pop_ready`=1.
  - `pop_source` alternates 0,1,0,1 (or 1,0,1,0); 1 beat/cycle.
- Backpressure: `pop_ready`=0, push 0 streams 0x01,0x02,0x03.
  - 0x01 goes to main, 0x02 to skid.
  - Then `push_ready`=0, `arb_request`=0, `arb_enable_priority_update`=0.
  - Raise `pop_ready`: pops are 0x01,0x02,0x03 in order.
- Fairness under stall: both pushes valid, `pop_ready`=0 after 2 beats.
  - LRU state is frozen while stalled.
  - On release, next grant goes to the requester not granted last.
- Reset mid-stream: assert `rst_n`=0 with both slots full.
  - `pop_valid`=0 immediately (asynchronous).
  - After release: `pop_valid` stays 0 until a new push.
- Stats (`BR_ARB_GRANT_SKID_STATS_EN`): 5 pops → `pop_count`=5.
  - Force the counter to 0xFFFFFFFF, do 1 more pop → value stays 0xFFFFFFFF.
